// File: rtl/nes_bus_pkg.sv
// Shared NES system-bus definitions: address type, default register addresses
// and the OAM DMA arbiter state encoding.
package nes_bus_pkg;

  typedef logic [15:0] bus_addr_t;

  localparam bus_addr_t DMA_REG_ADDR_DEF  = 16'h4014;
  localparam bus_addr_t OAM_DATA_ADDR_DEF = 16'h2004;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
  } dma_state_e;

endpackage

// File: rtl/oam_dma_arbiter.sv
// Arbitrates the system bus between the 6502 core and the 256-byte sprite DMA,
// stalling the CPU through RDY while a page is copied to the OAM data port.
module oam_dma_arbiter
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_r_nw,
  input  logic [7:0]  bus_data_in,
  output logic [15:0] addr_bus,
  output logic [7:0]  data_bus_out,
  output logic        r_nw,
  output logic        cpu_rdy,
  output logic        dma_active
);

  dma_state_e state_q, state_d;
  logic       parity_q;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] dma_data_q, dma_data_d;
  logic       cpu_rdy_q;
  logic       dma_active_q;
  bus_addr_t  src_addr;

  assign src_addr   = {page_q, idx_q};
  assign cpu_rdy    = cpu_rdy_q;
  assign dma_active = dma_active_q;

  always_ff @(posedge clk_ph1 or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      parity_q     <= 1'b0;
      page_q       <= 8'h00;
      idx_q        <= 8'h00;
      dma_data_q   <= 8'h00;
      cpu_rdy_q    <= 1'b1;
      dma_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      parity_q     <= ~parity_q;
      page_q       <= page_d;
      idx_q        <= idx_d;
      dma_data_q   <= dma_data_d;
      // RDY/active track the state being entered so they are valid in that cycle
      cpu_rdy_q    <= (state_d == ST_IDLE);
      dma_active_q <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d      = state_q;
    page_d       = page_q;
    idx_d        = idx_q;
    dma_data_d   = dma_data_q;
    addr_bus     = cpu_addr;
    data_bus_out = cpu_data_out;
    r_nw         = cpu_r_nw;

    case (state_q)
      ST_IDLE: begin
        if (!cpu_r_nw && (cpu_addr == DMA_REG_ADDR)) begin
          page_d  = cpu_data_out;
          idx_d   = 8'h00;
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        // The CPU only honours RDY on a read; writes still in flight pass through.
        if (cpu_r_nw) begin
          state_d = parity_q ? ST_READ : ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        state_d = ST_READ;
      end
      ST_READ: begin
        addr_bus     = src_addr;
        r_nw         = 1'b1;
        data_bus_out = 8'h00;
        dma_data_d   = bus_data_in;
        state_d      = ST_WRITE;
      end
      ST_WRITE: begin
        addr_bus     = OAM_DATA_ADDR;
        r_nw         = 1'b0;
        data_bus_out = dma_data_q;
        idx_d        = idx_q + 8'd1;
        state_d      = (idx_q == 8'hFF) ? ST_IDLE : ST_READ;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/oam_dma_arbiter.md
# oam_dma_arbiter

Bus arbiter between the 6502 CPU core and the sprite (OAM) DMA engine. A CPU write to the DMA register latches a source page. The block then stalls the CPU through RDY, takes the system address/data bus, and copies 256 bytes from page `$XX00–$XXFF` to the OAM data port. Outside DMA it passes the CPU bus through untouched. It sits between the CPU's bus outputs and the memory/PPU decode logic.

## Interface
Parameters:
- `DMA_REG_ADDR`, default `16'h4014`: CPU write address that triggers DMA.
- `OAM_DATA_ADDR`, default `16'h2004`: destination address for every DMA write.

Ports:
- `clk_ph1`  in  1  system clock. All state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `cpu_addr`  in  16  CPU address bus.
- `cpu_data_out`  in  8  CPU write data.
- `cpu_r_nw`  in  1  CPU read (1) / write (0).
- `bus_data_in`  in  8  read data returned from the system bus.
- `addr_bus`  out  16  arbitrated system address.
- `data_bus_out`  out  8  arbitrated write data.
- `r_nw`  out  1  arbitrated read/write strobe.
- `cpu_rdy`  out  1  CPU ready. 0 stalls the CPU on its next read cycle.
- `dma_active`  out  1  high while the DMA owns or is acquiring the bus.

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
- `parity` is a free-running 1-bit toggle, reset 0, flipping every clock.
  - A cycle with `parity==0` is a get cycle.
  - A cycle with `parity==1` is a put cycle.
- IDLE:
  - Bus outputs follow `cpu_addr`, `cpu_data_out` and `cpu_r_nw` combinationally.
  - When `cpu_r_nw==0 && cpu_addr==DMA_REG_ADDR`, latch `page<=cpu_data_out`, set `idx<=0`, and go to HALT.
- HALT:
  - `cpu_rdy=0`. The bus still passes the CPU signals, because the CPU may finish pending writes (RMW, stack pushes).
  - Stay in HALT while `cpu_r_nw==0`.
  - When `cpu_r_nw==1`, the CPU is now frozen. Go to READ if the current `parity==1`, otherwise go to ALIGN.
- ALIGN:
  - One dummy cycle. The bus passes the CPU read through, which is harmless because the CPU repeats it.
  - Go to READ.
- READ (always a get cycle):
  - Drive `addr_bus={page,idx}`, `r_nw=1`, `data_bus_out=8'h00`.
  - Capture `bus_data_in` into `dma_data` at the clock edge.
  - Go to WRITE.
- WRITE (always a put cycle):
  - Drive `addr_bus=OAM_DATA_ADDR`, `r_nw=0`, `data_bus_out=dma_data`.
  - Increment `idx` (8-bit).
  - If `idx==8'hFF` before the increment, go to IDLE; otherwise go to READ.
- `cpu_rdy` and `dma_active` are registered.
  - Both are 0/1 respectively in HALT, ALIGN, READ and WRITE.
  - Both are 1/0 respectively in IDLE.
- Boundary conditions:
  - `idx` wraps from FF to 00 exactly once per transfer.
  - Page `$FF` is legal and reads `$FF00–$FFFF`.
  - A trigger write to `DMA_REG_ADDR` while not in IDLE is ignored and `page` is unchanged. The CPU is stalled then, so this is defensive only.
  - A CPU read from `DMA_REG_ADDR` does not trigger.
  - Reset mid-transfer returns immediately to IDLE with pass-through and `cpu_rdy=1`; the partial transfer is abandoned.

## Timing
- Reset values:
  - state IDLE, `parity=0`, `page=0`, `idx=0`, `dma_data=0`.
  - `cpu_rdy=1`, `dma_active=0`.
  - Bus outputs equal the CPU inputs.
- Trigger write in cycle T: `cpu_rdy` falls and the state is HALT from T+1.
- If the CPU reads in T+1, the first READ is at T+2 (`parity(T+1)==1`) or T+3 (via ALIGN).
- Transfer body: exactly 512 cycles, 256 READ/WRITE pairs, alternating with no gaps.
- Stall length with an immediate read at T+1: 513 cycles (HALT + 512) or 514 (HALT + ALIGN + 512). Each extra CPU write cycle in HALT adds one cycle.
- After the last WRITE in cycle W, in cycle W+1 the state is IDLE, `cpu_rdy=1` and the bus is back to pass-through.
- All DMA bus outputs are decoded from registered state only, with no combinational path from `bus_data_in`.

## Structure
- Shared package `nes_bus_pkg` holds:
  - the state enum;
  - `DMA_REG_ADDR_DEF = 16'h4014` and `OAM_DATA_ADDR_DEF = 16'h2004`;
  - a 16-bit bus address type shared with the CPU and the PPU decode.
- Single module, no sub-module. The parity toggle, FSM, page/idx/data registers and output mux all fit in one file.

## Test plan
- **Idle pass-through:** CPU bus set to `16'h0102`, read, then `16'h0300` write of `8'hAB` -> outputs equal the inputs in the same cycle, `cpu_rdy=1`, `dma_active=0`.
- **Even start:**
  - Stimulus: memory page `$02` holds `i^8'h5A`; CPU writes `8'h02` to `$4014` in cycle T, reads at T+1, `parity(T+1)=1`.
  - Required: READ at T+2 of `$0200`; 256 writes to `$2004` carrying `5A,5B,…,A5` in order; `cpu_rdy` low for exactly 513 cycles; `cpu_rdy` back to 1 in the cycle after the last write.
- **Odd start:** same stimulus with `parity(T+1)=0` -> one ALIGN cycle, first READ at T+3, `cpu_rdy` low for exactly 514 cycles.
- **Pending CPU writes:** CPU issues 2 more write cycles (`$01FD`, `$01FC`) after the trigger -> both pass through to the bus unmodified; DMA starts only after the first CPU read; stall = 515 or 516 cycles.
- **Page `$FF`:** source `$FF00–$FFFF` read in order, `idx` wraps to 0, a single transfer of exactly 256 writes, then IDLE.
- **Reset mid-transfer and read decode:**
  - Stimulus: assert `rst=0` during write #100.
  - Required: asynchronously IDLE, `cpu_rdy=1`, pass-through, no further `$2004` writes.
  - A subsequent CPU read of `$4014` does not trigger DMA.
